// File: rtl/serdes_pkg.sv
// ============================================================================
// Module : serdes_pkg
// Brief  : Shared constants and types for the one-bit framed serial link.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serdes_pkg;

  localparam int SERDES_MAX_BITS = 2401;
  localparam int SERDES_LEN_W    = 33;

  typedef enum logic [1:0] {
    RX_SYNC,
    RX_IDLE,
    RX_RECV
  } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/deserializer_if.sv
// ============================================================================
// Module : deserializer_if
// Brief  : Serial input and framed valid/ready output bundle of the deserializer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface deserializer_if
  import serdes_pkg::*;
#(
  parameter int MAX_BITS = SERDES_MAX_BITS,
  parameter int LEN_W    = SERDES_LEN_W
);

  logic                serial_valid;
  logic                serial_data;
  logic                out_valid;
  logic                out_ready;
  logic [MAX_BITS-1:0] out_data;
  logic [LEN_W-1:0]    out_length;
  logic                overflow;
  logic                frame_dropped;

  // Driver side: serial source plus frame consumer
  modport master (
    output serial_valid,
    output serial_data,
    output out_ready,
    input  out_valid,
    input  out_data,
    input  out_length,
    input  overflow,
    input  frame_dropped
  );

  modport slave (
    input  serial_valid,
    input  serial_data,
    input  out_ready,
    output out_valid,
    output out_data,
    output out_length,
    output overflow,
    output frame_dropped
  );

endinterface

`default_nettype wire

// File: rtl/deserializer.sv
// ============================================================================
// Module : deserializer
// Brief  : Packs LSB-first serial frames into a word and hands each completed
//          frame to a valid/ready output register.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module deserializer
  import serdes_pkg::*;
#(
  parameter int MAX_BITS = SERDES_MAX_BITS,
  parameter int LEN_W    = SERDES_LEN_W
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  deserializer_if.slave bus
);

  localparam int             c_idx_w   = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
  localparam logic [LEN_W-1:0] c_max_len = LEN_W'(MAX_BITS);

  rx_state_t           r_state;
  rx_state_t           w_state_nxt;
  logic [MAX_BITS-1:0] r_buf;
  logic [LEN_W-1:0]    r_cnt;
  logic                r_ovf;
  logic                r_out_valid;
  logic [MAX_BITS-1:0] r_out_data;
  logic [LEN_W-1:0]    r_out_length;
  logic                r_out_ovf;
  logic                r_drop;

  logic                w_complete;
  logic                w_out_free;
  logic [c_idx_w-1:0]  w_idx;

  assign w_complete = (r_state == RX_RECV) && !bus.serial_valid;
  assign w_out_free = !r_out_valid || bus.out_ready;
  assign w_idx      = r_cnt[c_idx_w-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RX_SYNC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // SYNC waits for a gap so a reset released mid-frame never yields a partial frame
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RX_SYNC: if (!bus.serial_valid) w_state_nxt = RX_IDLE;
      RX_IDLE: if (bus.serial_valid)  w_state_nxt = RX_RECV;
      RX_RECV: if (!bus.serial_valid) w_state_nxt = RX_IDLE;
      default: w_state_nxt = RX_SYNC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf        <= '0;
      r_cnt        <= '0;
      r_ovf        <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_length <= '0;
      r_out_ovf    <= 1'b0;
      r_drop       <= 1'b0;
    end else begin
      r_drop <= 1'b0;

      case (r_state)
        RX_IDLE: begin
          if (bus.serial_valid) begin
            r_buf <= {{(MAX_BITS-1){1'b0}}, bus.serial_data};
            r_cnt <= LEN_W'(1);
            r_ovf <= 1'b0;
          end
        end
        RX_RECV: begin
          if (bus.serial_valid) begin
            if (r_cnt < c_max_len) begin
              r_buf[w_idx] <= bus.serial_data;
              r_cnt        <= r_cnt + LEN_W'(1);
            end else begin
              r_ovf <= 1'b1;
            end
          end
        end
        default: ;
      endcase

      // Capture buffer keeps running; only the handoff depends on the output slot
      if (w_complete) begin
        if (w_out_free) begin
          r_out_valid  <= 1'b1;
          r_out_data   <= r_buf;
          r_out_length <= r_cnt;
          r_out_ovf    <= r_ovf;
        end else begin
          r_drop <= 1'b1;
        end
      end else if (r_out_valid && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.out_valid     = r_out_valid;
  assign bus.out_data      = r_out_data;
  assign bus.out_length    = r_out_length;
  assign bus.overflow      = r_out_ovf;
  assign bus.frame_dropped = r_drop;

endmodule

`default_nettype wire

// File: tb/tb_deserializer.sv
// ============================================================================
// Module : tb_deserializer
// Brief  : Directed self-checking bench for the deserializer (MAX_BITS=16).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_deserializer;

  localparam int C_MAX = 16;
  localparam int C_LW  = 33;

  typedef struct {
    logic [C_MAX-1:0] data;
    int               len;
    logic             ovf;
  } rec_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   n_drops;
  rec_t q[$];

  deserializer_if #(.MAX_BITS(C_MAX), .LEN_W(C_LW)) bus ();

  deserializer #(.MAX_BITS(C_MAX), .LEN_W(C_LW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record accepted frames and drop pulses between active edges
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      rec_t r;
      r.data = bus.out_data;
      r.len  = int'(bus.out_length);
      r.ovf  = bus.overflow;
      q.push_back(r);
    end
    if (bus.frame_dropped) n_drops++;
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bits(input logic [63:0] value, input int len);
    for (int i = 0; i < len; i++) begin
      bus.serial_valid = 1'b1;
      bus.serial_data  = value[i];
      tick();
    end
  endtask

  task automatic send_frame(input logic [63:0] value, input int len);
    send_bits(value, len);
    bus.serial_valid = 1'b0;
    bus.serial_data  = 1'b0;
    tick();
  endtask

  task automatic clear_log();
    q.delete();
    n_drops = 0;
  endtask

  task automatic test_reset();
    rst_n            = 1'b0;
    bus.serial_valid = 1'b0;
    bus.serial_data  = 1'b0;
    bus.out_ready    = 1'b0;
    tick(3);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
    end
    n_checks++;
    if (bus.out_data !== 16'h0) begin
      n_fail++; $display("FAIL reset_out_data got=%h exp=0000", bus.out_data);
    end
    n_checks++;
    if (bus.out_length !== 33'd0) begin
      n_fail++; $display("FAIL reset_out_length got=%0d exp=0", bus.out_length);
    end
    n_checks++;
    if (bus.overflow !== 1'b0 || bus.frame_dropped !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags got=%b%b exp=00", bus.overflow, bus.frame_dropped);
    end
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_single();
    clear_log();
    bus.out_ready = 1'b1;
    send_frame(64'hA5, 8);
    n_checks++;
    if (bus.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL single_valid got=%b exp=1", bus.out_valid);
    end
    n_checks++;
    if (bus.out_data !== 16'h00A5 || bus.out_length !== 33'd8 || bus.overflow !== 1'b0) begin
      n_fail++; $display("FAIL single_frame got=%h/%0d/%b exp=00a5/8/0",
                         bus.out_data, bus.out_length, bus.overflow);
    end
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_valid_drop got=%b exp=0", bus.out_valid);
    end
    n_checks++;
    if (q.size() !== 1) begin
      n_fail++; $display("FAIL single_count got=%0d exp=1", q.size());
    end
    tick(2);
  endtask

  task automatic test_back_to_back();
    clear_log();
    bus.out_ready = 1'b1;
    send_frame(64'h3, 2);
    send_frame(64'h1, 3);
    tick(3);
    n_checks++;
    if (q.size() !== 2) begin
      n_fail++; $display("FAIL b2b_count got=%0d exp=2", q.size());
    end else begin
      n_checks++;
      if (q[0].data !== 16'h3 || q[0].len !== 2) begin
        n_fail++; $display("FAIL b2b_first got=%h/%0d exp=0003/2", q[0].data, q[0].len);
      end
      n_checks++;
      if (q[1].data !== 16'h1 || q[1].len !== 3) begin
        n_fail++; $display("FAIL b2b_second got=%h/%0d exp=0001/3", q[1].data, q[1].len);
      end
    end
    n_checks++;
    if (n_drops !== 0) begin
      n_fail++; $display("FAIL b2b_drops got=%0d exp=0", n_drops);
    end
  endtask

  task automatic test_hold();
    clear_log();
    bus.out_ready = 1'b0;
    send_frame(64'hF, 4);
    send_frame(64'h2, 2);
    tick(2);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h000F || bus.out_length !== 33'd4) begin
      n_fail++; $display("FAIL hold_output got=%b/%h/%0d exp=1/000f/4",
                         bus.out_valid, bus.out_data, bus.out_length);
    end
    n_checks++;
    if (n_drops !== 1) begin
      n_fail++; $display("FAIL hold_drops got=%0d exp=1", n_drops);
    end
    bus.out_ready = 1'b1;
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL hold_release_valid got=%b exp=0", bus.out_valid);
    end
    n_checks++;
    if (q.size() !== 1) begin
      n_fail++; $display("FAIL hold_count got=%0d exp=1", q.size());
    end else if (q[0].data !== 16'h000F || q[0].len !== 4) begin
      n_checks++;
      n_fail++; $display("FAIL hold_accepted got=%h/%0d exp=000f/4", q[0].data, q[0].len);
    end
    tick(2);
  endtask

  task automatic test_overflow();
    clear_log();
    bus.out_ready = 1'b1;
    send_frame(64'h1F_FFFF, C_MAX + 5);
    n_checks++;
    if (bus.out_data !== 16'hFFFF || bus.out_length !== 33'd16 || bus.overflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf_frame got=%h/%0d/%b exp=ffff/16/1",
                         bus.out_data, bus.out_length, bus.overflow);
    end
    tick();
    send_frame(64'h1, 1);
    n_checks++;
    if (bus.out_data !== 16'h0001 || bus.out_length !== 33'd1 || bus.overflow !== 1'b0) begin
      n_fail++; $display("FAIL ovf_clear got=%h/%0d/%b exp=0001/1/0",
                         bus.out_data, bus.out_length, bus.overflow);
    end
    tick(2);
  endtask

  task automatic test_reset_midframe();
    clear_log();
    bus.out_ready = 1'b1;
    send_bits(64'h1F, 5);
    #2 rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    send_bits(64'h7, 3);
    bus.serial_valid = 1'b0;
    tick(3);
    n_checks++;
    if (q.size() !== 0 || bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL midreset_no_frame got=%0d/%b exp=0/0", q.size(), bus.out_valid);
    end
    send_frame(64'h9, 4);
    tick(2);
    n_checks++;
    if (q.size() !== 1) begin
      n_fail++; $display("FAIL midreset_count got=%0d exp=1", q.size());
    end else if (q[0].data !== 16'h0009 || q[0].len !== 4 || q[0].ovf !== 1'b0) begin
      n_checks++;
      n_fail++; $display("FAIL midreset_frame got=%h/%0d/%b exp=0009/4/0",
                         q[0].data, q[0].len, q[0].ovf);
    end
  endtask

  task automatic test_simultaneous();
    clear_log();
    bus.out_ready = 1'b0;
    send_frame(64'h5, 3);
    send_bits(64'h6, 3);
    bus.serial_valid = 1'b0;
    bus.out_ready    = 1'b1;
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h0006 || bus.out_length !== 33'd3) begin
      n_fail++; $display("FAIL simul_load got=%b/%h/%0d exp=1/0006/3",
                         bus.out_valid, bus.out_data, bus.out_length);
    end
    tick(2);
    n_checks++;
    if (n_drops !== 0) begin
      n_fail++; $display("FAIL simul_drops got=%0d exp=0", n_drops);
    end
    n_checks++;
    if (q.size() !== 2) begin
      n_fail++; $display("FAIL simul_count got=%0d exp=2", q.size());
    end else if (q[0].data !== 16'h0005 || q[1].data !== 16'h0006) begin
      n_checks++;
      n_fail++; $display("FAIL simul_order got=%h,%h exp=0005,0006", q[0].data, q[1].data);
    end
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL simul_final_valid got=%b exp=0", bus.out_valid);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    n_drops  = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_hold();
    test_overflow();
    test_reset_midframe();
    test_simultaneous();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
